// File: rtl/mul_pkg.sv
// Shared definitions for the multipliers lab: controller state encoding and default width.
package mul_pkg;

  localparam int MUL_WIDTH = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/mul_pp_row.sv
// One partial-product row: conditionally adds the multiplicand to the running upper accumulator.
module mul_pp_row #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] u,
  input  logic             bsel,
  output logic [WIDTH:0]   s
);

  // Row sum is kept one bit wider so the carry-out survives into the shift
  always_comb begin
    s = {1'b0, u};
    if (bsel) begin
      s = {1'b0, x} + {1'b0, u};
    end else begin
      s = {1'b0, u};
    end
  end

endmodule

// File: rtl/seq_mul_ctrl.sv
// Shift-add sequential multiplier: one partial-product row per cycle, WIDTH cycles per product,
// with a start/busy/done handshake and a product register that only changes on completion.
module seq_mul_ctrl
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int               CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  mul_state_e       state_r;
  logic [WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0] acc_hi_r;
  logic [WIDTH-1:0] acc_lo_r;
  logic [CNT_W-1:0] count_r;
  logic [WIDTH:0]   row_s;

  mul_pp_row #(.WIDTH(WIDTH)) u_row (
    .x    (mcand_r),
    .u    (acc_hi_r),
    .bsel (acc_lo_r[0]),
    .s    (row_s)
  );

  // Controller FSM, accumulator shift register and registered handshake/product outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      product  <= {(2*WIDTH){1'b0}};
      count_r  <= {CNT_W{1'b0}};
      acc_hi_r <= {WIDTH{1'b0}};
      acc_lo_r <= {WIDTH{1'b0}};
      mcand_r  <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            mcand_r  <= a;
            acc_hi_r <= {WIDTH{1'b0}};
            acc_lo_r <= b;
            count_r  <= {CNT_W{1'b0}};
            busy     <= 1'b1;
            state_r  <= S_RUN;
          end else begin
            busy <= 1'b0;
          end
        end
        S_RUN: begin
          // The multiplier bits drain out of acc_lo as product bits shift in from the row sum
          acc_hi_r <= row_s[WIDTH:1];
          acc_lo_r <= {row_s[0], acc_lo_r[WIDTH-1:1]};
          count_r  <= count_r + CNT_W'(1);
          if (count_r == LAST_CNT) begin
            product <= {row_s, acc_lo_r[WIDTH-1:1]};
            done    <= 1'b1;
            busy    <= 1'b0;
            state_r <= S_DONE;
          end else begin
            busy <= 1'b1;
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule
